// File: rtl/elastic_reg_stage.sv
// One storage stage of the elastic pipe: a valid bit plus a data word that
// captures its source only when allowed to advance.
module elastic_reg_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             ld,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v <= 1'b0;
            d <= '0;
        end else begin
            if (flush) begin
                v <= 1'b0;
            end else if (ld) begin
                v <= src_valid;
            end
            // Data moves only with a valid word, so an emptied stage keeps its last value.
            if (!flush && ld && src_valid) begin
                d <= src_data;
            end
        end
    end

endmodule

// File: rtl/elastic_reg_pipe.sv
// DEPTH-stage elastic register pipeline with bubble collapse, synchronous
// flush and a registered occupancy count.
module elastic_reg_pipe #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    occupancy
);

    // Handshake: a word moves across a port at a rising edge exactly when
    // valid and ready are both high at that edge; valid never waits on ready.

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] ld;
    logic [WIDTH-1:0] d [DEPTH];
    logic             in_xfer;
    logic             out_xfer;

    // A stage may load when it, or any stage nearer the output, has room.
    always_comb begin : ld_chain
        logic room;
        room = out_ready;
        ld   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            room  = room | ~v[i];
            ld[i] = room;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             sv;
        logic [WIDTH-1:0] sd;
        if (i == 0) begin : g_head
            assign sv = in_valid;
            assign sd = in_data;
        end else begin : g_body
            assign sv = v[i-1];
            assign sd = d[i-1];
        end
        elastic_reg_stage #(.WIDTH(WIDTH)) u_stage (
            .clk       (clk),
            .reset_n   (reset_n),
            .flush     (flush),
            .ld        (ld[i]),
            .src_valid (sv),
            .src_data  (sd),
            .v         (v[i]),
            .d         (d[i])
        );
    end

    assign in_ready  = ld[0];
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (in_xfer && !out_xfer) begin
            occupancy <= occupancy + CW'(1);
        end else if (!in_xfer && out_xfer) begin
            occupancy <= occupancy - CW'(1);
        end
    end

endmodule

// File: tb/tb_elastic_reg_pipe.sv
// Self-checking bench for elastic_reg_pipe: position-based reference model,
// per-cycle output compare, word-order scoreboard, directed and random stimulus.
module tb_elastic_reg_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    occupancy;

    elastic_reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total_cnt = 0;
    int pass_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // reference model: words in flight, oldest first, each with its stage position
    typedef struct {
        int               pos;
        logic [WIDTH-1:0] data;
    } ent_t;

    ent_t             mq[$];
    logic [WIDTH-1:0] mlast;
    logic [WIDTH-1:0] exp_q[$];
    logic             samp_ov;
    logic [WIDTH-1:0] samp_od;

    function automatic bit m_out_valid();
        return (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
    endfunction

    function automatic bit m_in_ready();
        return (mq.size() < DEPTH) || out_ready;
    endfunction

    task automatic model_step();
        bit   in_x;
        bit   out_x;
        bit   stuck_prev;
        int   old_prev;
        ent_t e;
        in_x  = in_valid && m_in_ready();
        out_x = m_out_valid() && out_ready;
        if (samp_ov && out_ready) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("sb_data", 32'(samp_od), 32'(exp_q.pop_front()));
        end
        if (out_x) void'(mq.pop_front());
        if (flush) begin
            mq.delete();
            exp_q.delete();
            return;
        end
        // Without out_ready, a word stays put only if everything ahead of it is packed to the output.
        stuck_prev = 1'b0;
        old_prev   = 0;
        for (int k = 0; k < mq.size(); k++) begin
            int p;
            bit stuck;
            p     = mq[k].pos;
            stuck = !out_ready && ((k == 0) ? (p == DEPTH - 1) : (stuck_prev && old_prev == p + 1));
            stuck_prev = stuck;
            old_prev   = p;
            if (!stuck) mq[k].pos = p + 1;
            if (mq[k].pos == DEPTH - 1) mlast = mq[k].data;
        end
        if (in_x) begin
            e.pos  = 0;
            e.data = in_data;
            mq.push_back(e);
            exp_q.push_back(in_data);
            if (DEPTH == 1) mlast = in_data;
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            exp_q.delete();
            mlast = '0;
        end else begin
            model_step();
        end
    end

    // per-cycle compare, away from the active edge
    always @(negedge clk) begin
        samp_ov = out_valid;
        samp_od = out_data;
        chk("out_valid", 32'(out_valid), 32'(m_out_valid()));
        chk("out_data",  32'(out_data),  32'(mlast));
        chk("in_ready",  32'(in_ready),  32'(m_in_ready()));
        chk("occupancy", 32'(occupancy), 32'(mq.size()));
    end

    // driver tasks
    task automatic drive(input bit iv, input logic [WIDTH-1:0] dat, input bit ordy, input bit fl);
        in_valid  = iv;
        in_data   = dat;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic step_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        step_n(2);
        reset_n = 1'b1;
        step_n(1);

        // streaming with latency pin
        drive(1'b1, 8'h01, 1'b1, 1'b0);
        step_n(1);
        drive(1'b1, 8'h02, 1'b1, 1'b0);
        step_n(1);
        drive(1'b1, 8'h03, 1'b1, 1'b0);
        step_n(1);
        chk("lat_not_yet", 32'(out_valid), 32'd0);
        drive(1'b1, 8'h04, 1'b1, 1'b0);
        step_n(1);
        chk("lat_first_ov",   32'(out_valid), 32'd1);
        chk("lat_first_data", 32'(out_data),  32'h01);
        for (int w = 5; w <= 16; w++) begin
            drive(1'b1, 8'(w), 1'b1, 1'b0);
            step_n(1);
            chk("stream_occ", 32'(occupancy), 32'd4);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step_n(6);

        // backpressure fill
        for (int w = 0; w < 4; w++) begin
            drive(1'b1, 8'hA1 + 8'(w), 1'b0, 1'b0);
            step_n(1);
        end
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("bp_in_ready", 32'(in_ready),  32'd0);
        chk("bp_occ",      32'(occupancy), 32'd4);
        chk("bp_head",     32'(out_data),  32'hA1);
        step_n(2);
        chk("bp_hold_occ", 32'(occupancy), 32'd4);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", 32'(in_ready), 32'd1);
        step_n(1);
        chk("bp_next_head", 32'(out_data), 32'hA2);
        drive(1'b0, '0, 1'b1, 1'b0);
        step_n(6);

        // bubble collapse
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        step_n(1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step_n(2);
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        step_n(1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step_n(3);
        chk("bub_occ",  32'(occupancy), 32'd2);
        chk("bub_head", 32'(out_data),  32'h11);
        out_ready = 1'b1;
        step_n(1);
        chk("bub_second", 32'(out_data), 32'h22);
        step_n(5);

        // full push/pop
        for (int w = 0; w < 4; w++) begin
            drive(1'b1, 8'hB0 + 8'(w), 1'b0, 1'b0);
            step_n(1);
        end
        for (int w = 0; w < 8; w++) begin
            drive(1'b1, 8'hC0 + 8'(w), 1'b1, 1'b0);
            step_n(1);
            chk("full_pp_occ", 32'(occupancy), 32'd4);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step_n(6);

        // flush with a pending input and a delivered head
        for (int w = 0; w < 3; w++) begin
            drive(1'b1, 8'hD1 + 8'(w), 1'b0, 1'b0);
            step_n(1);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        step_n(1);
        chk("fl_pre_occ", 32'(occupancy), 32'd3);
        drive(1'b1, 8'hEE, 1'b1, 1'b1);
        step_n(1);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("fl_occ",  32'(occupancy), 32'd0);
        chk("fl_ov",   32'(out_valid), 32'd0);
        chk("fl_hold", 32'(out_data),  32'hD1);
        step_n(6);

        // asynchronous reset mid-stream
        for (int w = 0; w < 3; w++) begin
            drive(1'b1, 8'h31 + 8'(w), 1'b0, 1'b0);
            step_n(1);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("ar_pre_occ", 32'(occupancy), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_occupancy", 32'(occupancy), 32'd0);
        chk("ar_out_data",  32'(out_data),  32'd0);
        chk("ar_in_ready",  32'(in_ready),  32'd1);
        step_n(2);
        reset_n = 1'b1;
        step_n(1);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            bit ordy;
            ordy = (c % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            drive($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)), ordy,
                  $urandom_range(0, 60) == 0);
            step_n(1);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        step_n(8);
        chk("drain_occ", 32'(occupancy), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
